ifetch_line_buf: RTL

IFETCH_LINE_BUF -- requirements
Module: ifetch_line_buf

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_line_ram.sv | 26 ++
 rtl/ifetch_line_buf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and AXI constants for the instruction line buffer.
// Imported by ifetch_line_buf and ifetch_line_ram.
package ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    SERVE,
    DRAIN,
    STOP
  } fetch_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ifetch_line_ram.sv
// One cache line of storage: DEPTH x WIDTH, sync write, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module ifetch_line_ram
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_line_buf.sv
// Single-line instruction fetch buffer: AXI burst fill, 32-bit serve.
// Ports: clk/reset_n, entry, redirect, inst handshake, halt/fault, AXI AR+R.
module ifetch_line_buf
  import ifetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          ID_WIDTH   = 13,
  parameter int          LINE_BEATS = 8,
  parameter int unsigned FETCH_ID   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  halt,
  output logic                  fault,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int LB = LINE_BEATS * 8;
  localparam int OB = $clog2(LB);
  localparam int IW = $clog2(LINE_BEATS);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] rd_lat;
  logic                  rd_pend;
  logic [IW-1:0]         cnt;
  logic                  fault_q;
  logic                  halt_q;

  logic [DATA_WIDTH-1:0] line_word;
  logic [31:0]           word;
  logic                  zero;
  logic                  in_serve;
  logic                  bad;
  logic                  fault_n;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] rd_pc;
  logic [ADDR_WIDTH-1:0] entry_pc;
  logic                  unused;

  assign rd_pc    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign entry_pc = {entry[ADDR_WIDTH-1:2], 2'b00};
  assign unused   = ^{entry[1:0], redirect_pc[1:0], m_axi_rid};

  ifetch_line_ram #(
    .DEPTH(LINE_BEATS),
    .WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (state == FILL && m_axi_rvalid),
    .waddr(cnt),
    .wdata(m_axi_rdata),
    .raddr(pc[OB-1:3]),
    .rdata(line_word)
  );

  assign word      = pc[2] ? line_word[63:32] : line_word[31:0];
  assign zero      = (word == 32'h0);
  assign in_serve  = (state == SERVE);
  assign bad       = m_axi_rvalid && (m_axi_rresp != AXI_RESP_OKAY);
  assign fault_n   = fault_q || bad;
  assign last_beat = m_axi_rvalid && m_axi_rlast;

  assign inst_valid = in_serve && !zero;
  assign inst_data  = inst_valid ? word : 32'h0;
  assign inst_pc    = pc;
  // Halt shows in the same cycle the zero word is seen, then latches.
  assign halt  = halt_q || (in_serve && zero && !redirect_valid);
  assign fault = fault_q;

  assign m_axi_arvalid = (state == REQ);
  assign m_axi_araddr  = {pc[ADDR_WIDTH-1:OB], OB'(0)};
  assign m_axi_arlen   = 8'(LINE_BEATS - 1);
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = ID_WIDTH'(FETCH_ID);
  assign m_axi_rready  = (state == FILL) || (state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= '0;
      rd_lat  <= '0;
      rd_pend <= 1'b0;
      cnt     <= '0;
      fault_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pc    <= redirect_valid ? rd_pc : entry_pc;
          state <= REQ;
        end
        REQ: begin
          // AR stays untouched; a redirect only gets remembered.
          if (redirect_valid) begin
            rd_lat  <= rd_pc;
            rd_pend <= 1'b1;
          end
          if (m_axi_arready) begin
            cnt     <= '0;
            rd_pend <= 1'b0;
            state   <= (rd_pend || redirect_valid) ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (m_axi_rvalid) begin
            cnt <= cnt + 1'b1;
            if (bad) fault_q <= 1'b1;
          end
          if (last_beat) begin
            if (fault_n) begin
              state <= STOP;
            end else if (redirect_valid) begin
              pc    <= rd_pc;
              state <= REQ;
            end else begin
              state <= SERVE;
            end
          end else if (redirect_valid) begin
            rd_lat <= rd_pc;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_valid) rd_lat <= rd_pc;
          if (last_beat) begin
            if (fault_q) begin
              state <= STOP;
            end else begin
              pc    <= redirect_valid ? rd_pc : rd_lat;
              state <= REQ;
            end
          end
        end
        SERVE: begin
          if (redirect_valid) begin
            pc    <= rd_pc;
            state <= REQ;
          end else if (zero) begin
            halt_q <= 1'b1;
            state  <= STOP;
          end else if (inst_ready) begin
            pc <= pc + ADDR_WIDTH'(4);
            if (&pc[OB-1:2]) state <= REQ;
          end
        end
        STOP: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
